// File: rtl/cdb_arbiter.sv
// CDB transmit side: per-unit result FIFOs arbitrated onto one registered broadcast per cycle.
// Define CDB_FIXED_PRIO_EN for fixed lowest-index priority; the default build uses round robin.
module cdb_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int BUF_DEPTH  = 2,
    parameter int TAG_WIDTH  = 6,
    parameter int DATA_WIDTH = 32,
    localparam int SRC_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_flush,
    input  logic [NUM_UNITS-1:0]            i_unit_valid,
    input  logic [NUM_UNITS*TAG_WIDTH-1:0]  i_unit_tag,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] i_unit_data,
    output logic [NUM_UNITS-1:0]            o_unit_ready,
    output logic                            o_cdb_valid,
    output logic [TAG_WIDTH-1:0]            o_cdb_tag,
    output logic [DATA_WIDTH-1:0]           o_cdb_data,
    output logic [SRC_W-1:0]                o_cdb_src,
    output logic                            o_busy
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [TAG_WIDTH-1:0]  q_tag  [NUM_UNITS][BUF_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [NUM_UNITS][BUF_DEPTH];
    logic [PTR_W-1:0]      rd_ptr [NUM_UNITS];
    logic [PTR_W-1:0]      wr_ptr [NUM_UNITS];
    logic [CNT_W-1:0]      count  [NUM_UNITS];

    logic [NUM_UNITS-1:0]  req;
    logic [NUM_UNITS-1:0]  push;
    logic [NUM_UNITS-1:0]  pop;
    logic                  grant_valid;
    logic [SRC_W-1:0]      grant_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Ready depends only on registered occupancy, never on valid or the grant.
    always_comb begin
        req          = '0;
        o_unit_ready = '0;
        push         = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            req[u]          = (count[u] != '0);
            o_unit_ready[u] = (count[u] != CNT_W'(BUF_DEPTH));
            push[u]         = i_unit_valid[u] & o_unit_ready[u];
        end
    end

    assign o_busy = (|req) | o_cdb_valid;

`ifdef CDB_FIXED_PRIO_EN
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'(i);
            end
        end
    end
`else
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W:0]   rr_sum;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_sum      = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            rr_sum = {1'b0, rr_ptr} + (SRC_W+1)'(i);
            if (rr_sum >= (SRC_W+1)'(NUM_UNITS)) rr_sum = rr_sum - (SRC_W+1)'(NUM_UNITS);
            if (!grant_valid && req[rr_sum[SRC_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = rr_sum[SRC_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (grant_idx == SRC_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    always_comb begin
        pop = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            pop[u] = grant_valid && (grant_idx == SRC_W'(u));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            o_cdb_valid <= 1'b0;
            o_cdb_tag   <= '0;
            o_cdb_data  <= '0;
            o_cdb_src   <= '0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                rd_ptr[u] <= '0;
                wr_ptr[u] <= '0;
                count[u]  <= '0;
            end
        end else begin
            o_cdb_valid <= grant_valid;
            o_cdb_tag   <= grant_valid ? q_tag[grant_idx][rd_ptr[grant_idx]] : '0;
            o_cdb_data  <= grant_valid ? q_data[grant_idx][rd_ptr[grant_idx]] : '0;
            o_cdb_src   <= grant_valid ? grant_idx : '0;
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (push[u]) wr_ptr[u] <= ptr_inc(wr_ptr[u]);
                if (pop[u])  rd_ptr[u] <= ptr_inc(rd_ptr[u]);
                count[u] <= count[u] + CNT_W'(push[u]) - CNT_W'(pop[u]);
            end
        end
    end

    // Entry storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (push[u]) begin
                    q_tag[u][wr_ptr[u]]  <= i_unit_tag[u*TAG_WIDTH +: TAG_WIDTH];
                    q_data[u][wr_ptr[u]] <= i_unit_data[u*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed pushes with hand-ordered expected broadcasts in a scoreboard.
// Expected orders under CDB_FIXED_PRIO_EN follow lowest-index priority.
module tb_cdb_arbiter;
    localparam int NU = 4;
    localparam int TW = 6;
    localparam int DW = 32;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic [1:0]    src;
    } bc_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [NU-1:0]    unit_valid = '0;
    logic [NU*TW-1:0] unit_tag = '0;
    logic [NU*DW-1:0] unit_data = '0;
    logic [NU-1:0]    unit_ready;
    logic             cdb_valid;
    logic [TW-1:0]    cdb_tag;
    logic [DW-1:0]    cdb_data;
    logic [1:0]       cdb_src;
    logic             busy;

    bc_t exp_q[$];
    bc_t mon_e;
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_unit_valid (unit_valid),
        .i_unit_tag   (unit_tag),
        .i_unit_data  (unit_data),
        .o_unit_ready (unit_ready),
        .o_cdb_valid  (cdb_valid),
        .o_cdb_tag    (cdb_tag),
        .o_cdb_data   (cdb_data),
        .o_cdb_src    (cdb_src),
        .o_busy       (busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] dv(input logic [TW-1:0] t);
        return 32'hC0DE_0000 | {26'h0, t};
    endfunction

    task automatic drive(input int u, input logic [TW-1:0] t, input logic [DW-1:0] d);
        unit_valid[u]         = 1'b1;
        unit_tag[u*TW +: TW]  = t;
        unit_data[u*DW +: DW] = d;
    endtask

    task automatic clear();
        unit_valid = '0;
        unit_tag   = '0;
        unit_data  = '0;
    endtask

    task automatic expect_bc(input logic [TW-1:0] t, input logic [DW-1:0] d, input int src);
        exp_q.push_back({t, d, 2'(src)});
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        clear();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_valid"}, cdb_valid, 0);
        check({name, "_tag"}, cdb_tag, 0);
        check({name, "_data"}, cdb_data, 0);
        check({name, "_src"}, cdb_src, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_ready"}, unit_ready, 4'b1111);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 60) begin
            tick();
            n++;
        end
        check({name, "_drain_q"}, exp_q.size(), 0);
        check({name, "_drain_busy"}, busy, 0);
    endtask

    // Scoreboard monitor: every broadcast beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (cdb_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cdb_unexpected actual tag=%0h data=%0h src=%0d required no broadcast",
                         cdb_tag, cdb_data, cdb_src);
            end else begin
                mon_e = exp_q.pop_front();
                if ({cdb_tag, cdb_data, cdb_src} !== mon_e) begin
                    errors++;
                    $display("FAIL cdb_bcast actual tag=%0h data=%0h src=%0d required tag=%0h data=%0h src=%0d",
                             cdb_tag, cdb_data, cdb_src, mon_e.tag, mon_e.data, mon_e.src);
                end
            end
        end
    end

    initial begin
        int idx0, idx3;
        logic acc0, acc3;

        // 1: reset values and single-push latency
        do_reset();
        check_idle_outputs("s1_reset");
        drive(2, 6'h15, 32'hDEAD_BEEF);
        expect_bc(6'h15, 32'hDEAD_BEEF, 2);
        tick();
        clear();
        check("s1_lat_k_valid", cdb_valid, 0);
        check("s1_lat_k_busy", busy, 1);
        tick();
        check("s1_lat_k1_valid", cdb_valid, 1);
        check("s1_lat_k1_src", cdb_src, 2);
        tick();
        check("s1_k2_valid", cdb_valid, 0);
        check("s1_k2_busy", busy, 0);

        // 2: four simultaneous pushes, then a late push from unit 0
        do_reset();
        for (int u = 0; u < NU; u++) begin
            drive(u, 6'(u + 1), dv(6'(u + 1)));
            expect_bc(6'(u + 1), dv(6'(u + 1)), u);
        end
        expect_bc(6'h05, dv(6'h05), 0);
        tick();
        clear();
        tick();
        check("s2_first_src", cdb_src, 0);
        tick();
        tick();
        check("s2_third_src", cdb_src, 2);
        drive(0, 6'h05, dv(6'h05));
        tick();
        clear();
        check("s2_fourth_src", cdb_src, 3);
        wait_drain("s2");

        // 3: fill unit 1 behind competition; tag 10 held until accepted
        do_reset();
        expect_bc(6'h20, dv(6'h20), 0);
        expect_bc(6'h08, dv(6'h08), 1);
`ifdef CDB_FIXED_PRIO_EN
        expect_bc(6'h09, dv(6'h09), 1);
        expect_bc(6'h0A, dv(6'h0A), 1);
        expect_bc(6'h22, dv(6'h22), 2);
`else
        expect_bc(6'h22, dv(6'h22), 2);
        expect_bc(6'h09, dv(6'h09), 1);
        expect_bc(6'h0A, dv(6'h0A), 1);
`endif
        drive(0, 6'h20, dv(6'h20));
        drive(1, 6'h08, dv(6'h08));
        drive(2, 6'h22, dv(6'h22));
        tick();
        clear();
        check("s3_ready_e1", unit_ready, 4'b1111);
        drive(1, 6'h09, dv(6'h09));
        tick();
        check("s3_ready_full", unit_ready, 4'b1101);
        drive(1, 6'h0A, dv(6'h0A));
        tick();
        check("s3_ready_after_pop", unit_ready, 4'b1111);
        tick();
        clear();
`ifdef CDB_FIXED_PRIO_EN
        check("s3_ready_e4", unit_ready, 4'b1111);
`else
        check("s3_ready_e4", unit_ready, 4'b1101);
`endif
        wait_drain("s3");

        // 4: units 0 and 3 continuously valid for 8 cycles
        do_reset();
`ifdef CDB_FIXED_PRIO_EN
        for (int i = 0; i < 8; i++) expect_bc(6'(6'h30 + i), dv(6'(6'h30 + i)), 0);
        for (int i = 0; i < 2; i++) expect_bc(6'(6'h38 + i), dv(6'(6'h38 + i)), 3);
`else
        for (int i = 0; i < 5; i++) begin
            expect_bc(6'(6'h30 + i), dv(6'(6'h30 + i)), 0);
            expect_bc(6'(6'h38 + i), dv(6'(6'h38 + i)), 3);
        end
`endif
        idx0 = 0;
        idx3 = 0;
        acc0 = 1'b0;
        acc3 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (acc0) idx0++;
            if (acc3) idx3++;
            drive(0, 6'(6'h30 + idx0), dv(6'(6'h30 + idx0)));
            drive(3, 6'(6'h38 + idx3), dv(6'(6'h38 + idx3)));
            acc0 = unit_ready[0];
            acc3 = unit_ready[3];
            tick();
        end
        clear();
        wait_drain("s4");

        // 5: flush with three entries queued and a same-cycle push of tag 3F
        do_reset();
        expect_bc(6'h11, dv(6'h11), 1);
        drive(1, 6'h11, dv(6'h11));
        drive(2, 6'h12, dv(6'h12));
        drive(3, 6'h13, dv(6'h13));
        tick();
        clear();
        drive(1, 6'h14, dv(6'h14));
        tick();
        clear();
        drive(0, 6'h3F, dv(6'h3F));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear();
        check_idle_outputs("s5_flush");
        expect_bc(6'h2B, dv(6'h2B), 1);
        expect_bc(6'h2C, dv(6'h2C), 3);
        drive(1, 6'h2B, dv(6'h2B));
        drive(3, 6'h2C, dv(6'h2C));
        tick();
        clear();
        wait_drain("s5");

        // 6: reset together with flush and pushes mid-stream
        expect_bc(6'h31, dv(6'h31), 0);
        drive(0, 6'h31, dv(6'h31));
        drive(1, 6'h32, dv(6'h32));
        drive(2, 6'h33, dv(6'h33));
        tick();
        clear();
        tick();
        rst   = 1'b1;
        flush = 1'b1;
        drive(3, 6'h34, dv(6'h34));
        drive(1, 6'h35, dv(6'h35));
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        clear();
        check_idle_outputs("s6_rst");
        expect_bc(6'h36, dv(6'h36), 0);
        expect_bc(6'h37, dv(6'h37), 2);
        drive(0, 6'h36, dv(6'h36));
        drive(2, 6'h37, dv(6'h37));
        tick();
        clear();
        wait_drain("s6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
